// File: rtl/free_list_if.sv
// Rename-stage free-list port bundle: dispatch alloc, retire free and squash.
// The free list itself takes the slave side; dispatch/retire logic drives the master side.
interface free_list_if #(
    parameter int unsigned N     = 2,
    parameter int unsigned TAG_W = 6,
    parameter int unsigned CNT_W = 6
);
    logic [N-1:0]            alloc_req;
    logic [N-1:0][TAG_W-1:0] alloc_tags;
    logic                    alloc_ok;
    logic [CNT_W-1:0]        avail_count;
    logic [N-1:0]            retire_en;
    logic [N-1:0][TAG_W-1:0] retire_free_tags;
    logic                    mispredict;

    modport master (
        output alloc_req,
        output retire_en,
        output retire_free_tags,
        output mispredict,
        input  alloc_tags,
        input  alloc_ok,
        input  avail_count
    );

    modport slave (
        input  alloc_req,
        input  retire_en,
        input  retire_free_tags,
        input  mispredict,
        output alloc_tags,
        output alloc_ok,
        output avail_count
    );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register tags with a speculative head for dispatch
// and an architectural head that lets a mispredict reclaim wrong-path tags in one cycle.
module free_list #(
    parameter int unsigned N           = 2,
    parameter int unsigned PHYS_REG_SZ = 64,
    parameter int unsigned ARCH_REG_SZ = 32
) (
    input  logic       i_clock,
    input  logic       i_reset,
    free_list_if.slave fl
);
    // DEPTH must be a power of two so index = low pointer bits wraps naturally.
    localparam int unsigned DEPTH = PHYS_REG_SZ - ARCH_REG_SZ;
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned TAG_W = $clog2(PHYS_REG_SZ);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SEL_W = $clog2(N + 1);

    logic [TAG_W-1:0]          r_tag [DEPTH];
    logic [PTR_W-1:0]          r_spec_head;
    logic [PTR_W-1:0]          r_arch_head;
    logic [PTR_W-1:0]          r_tail;

    logic [SEL_W-1:0]          w_req_cnt;
    logic [SEL_W-1:0]          w_free_cnt;
    logic [N-1:0][SEL_W-1:0]   w_req_ofs;
    logic [N-1:0][SEL_W-1:0]   w_free_ofs;
    logic [N-1:0][IDX_W-1:0]   w_rd_idx;
    logic [N-1:0][IDX_W-1:0]   w_wr_idx;
    logic [PTR_W-1:0]          w_avail;
    logic [PTR_W-1:0]          w_inflight;
    logic [PTR_W-1:0]          w_occupied;
    logic [PTR_W-1:0]          w_spec_nxt;
    logic                      w_alloc_ok;
    logic                      w_bad_free;

    // Exclusive prefix popcounts: slot i uses the entry after all lower requesting slots.
    always_comb begin
        w_req_cnt  = '0;
        w_free_cnt = '0;
        w_req_ofs  = '0;
        w_free_ofs = '0;
        w_bad_free = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_req_ofs[i]  = w_req_cnt;
            w_free_ofs[i] = w_free_cnt;
            w_req_cnt     = w_req_cnt + SEL_W'(fl.alloc_req[i]);
            w_free_cnt    = w_free_cnt + SEL_W'(fl.retire_en[i]);
            if (fl.retire_en[i] && (fl.retire_free_tags[i] == '0)) begin
                w_bad_free = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_idx = '0;
        w_wr_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_rd_idx[i] = IDX_W'(r_spec_head + PTR_W'(w_req_ofs[i]));
            w_wr_idx[i] = IDX_W'(r_tail + PTR_W'(w_free_ofs[i]));
        end
    end

    assign w_avail    = r_tail - r_spec_head;
    assign w_inflight = r_spec_head - r_arch_head;
    assign w_occupied = r_tail - r_arch_head;
    assign w_alloc_ok = (PTR_W'(w_req_cnt) <= w_avail);

    // Grants are all-or-nothing; a tag freed this cycle is not visible until the next one.
    always_comb begin
        fl.alloc_ok    = w_alloc_ok;
        fl.avail_count = CNT_W'(w_avail);
        fl.alloc_tags  = '0;
        for (int i = 0; i < N; i++) begin
            fl.alloc_tags[i] = r_tag[w_rd_idx[i]];
        end
    end

    // Squash wins over allocation and restores to the post-retire architectural head.
    always_comb begin
        w_spec_nxt = r_spec_head;
        if (fl.mispredict) begin
            w_spec_nxt = r_arch_head + PTR_W'(w_free_cnt);
        end else if (w_alloc_ok) begin
            w_spec_nxt = r_spec_head + PTR_W'(w_req_cnt);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_spec_head <= '0;
            r_arch_head <= '0;
            r_tail      <= PTR_W'(DEPTH);
        end else begin
            r_spec_head <= w_spec_nxt;
            r_arch_head <= r_arch_head + PTR_W'(w_free_cnt);
            r_tail      <= r_tail + PTR_W'(w_free_cnt);
        end
    end

    // Reset contents: the non-architectural tags ARCH_REG_SZ .. PHYS_REG_SZ-1 in order.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_tag[k] <= TAG_W'(ARCH_REG_SZ + k);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (fl.retire_en[i]) begin
                    r_tag[w_wr_idx[i]] <= fl.retire_free_tags[i];
                end
            end
        end
    end

    a_head_order: assert property (@(posedge i_clock) disable iff (!i_reset)
        w_inflight <= w_occupied);

    a_capacity: assert property (@(posedge i_clock) disable iff (!i_reset)
        w_occupied <= PTR_W'(DEPTH));

    a_over_retire: assert property (@(posedge i_clock) disable iff (!i_reset)
        PTR_W'(w_free_cnt) <= w_inflight);

    a_zero_free: assert property (@(posedge i_clock) disable iff (!i_reset)
        !w_bad_free);

endmodule
